// File: rtl/imm_gen_if.sv
// Handshake bundle for imm_gen_pipe: instruction in, decoded immediate out.
// The master drives instructions and consumes results; the slave is the decoder.
interface imm_gen_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: combinational decode feeding a 2-entry skid FIFO.
// Results (including illegal ones) leave in acceptance order, one cycle after entry.
module imm_gen_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter bit          ENABLE_CSR = 1'b1
) (
    input  logic      clk,
    input  logic      rst_n,
    imm_gen_if.slave  bus
);
    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtZ    = 3'd6
    } fmt_e;

    logic [31:0]     w_instr;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;

    logic [XLEN-1:0] r_imm [2];
    fmt_e            r_fmt [2];
    logic            r_illegal [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];

    always_comb begin
        w_imm     = '0;
        w_fmt     = FmtNone;
        w_illegal = 1'b0;
        if (w_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
                    w_fmt = FmtI;
                    w_imm = XLEN'($signed(w_instr[31:20]));
                end
                7'b0100011: begin
                    w_fmt = FmtS;
                    w_imm = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
                end
                7'b1100011: begin
                    w_fmt = FmtB;
                    w_imm = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                           w_instr[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    w_fmt = FmtU;
                    w_imm = XLEN'($signed({w_instr[31:12], 12'b0}));
                end
                7'b1101111: begin
                    w_fmt = FmtJ;
                    w_imm = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                           w_instr[30:21], 1'b0}));
                end
                7'b1110011: begin
                    if (w_funct3 == 3'b000) begin
                        w_fmt = FmtI;
                        w_imm = XLEN'($signed(w_instr[31:20]));
                    end else if (!ENABLE_CSR) begin
                        w_illegal = 1'b1;
                    end else if (w_funct3[2]) begin
                        // CSR immediate forms carry a 5-bit unsigned zimm in rs1
                        w_fmt = FmtZ;
                        w_imm = XLEN'(w_instr[19:15]);
                    end else begin
                        w_fmt = FmtI;
                        w_imm = XLEN'($signed(w_instr[31:20]));
                    end
                end
                7'b0110011, 7'b0111011: begin
                    w_fmt = FmtNone;
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_count < 2'd2);
    assign bus.out_valid = (r_count != 2'd0);
    assign w_push        = bus.in_valid && bus.in_ready;
    assign w_pop         = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_imm[i]     <= '0;
                r_fmt[i]     <= FmtNone;
                r_illegal[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_imm[r_wr_ptr]     <= w_imm;
                r_fmt[r_wr_ptr]     <= w_fmt;
                r_illegal[r_wr_ptr] <= w_illegal;
                r_wr_ptr            <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_imm     = r_imm[r_rd_ptr];
    assign bus.out_fmt     = r_fmt[r_rd_ptr];
    assign bus.out_illegal = r_illegal[r_rd_ptr];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: main 32-bit DUT plus XLEN=64 and CSR-disabled copies
// driven in lockstep, checked with immediate assertions against hand-computed values.
module tb_imm_gen_pipe;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    imm_gen_if #(.XLEN(32)) bus ();
    imm_gen_if #(.XLEN(64)) bus64 ();
    imm_gen_if #(.XLEN(32)) busnc ();

    imm_gen_pipe #(.XLEN(32), .ENABLE_CSR(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    imm_gen_pipe #(.XLEN(64), .ENABLE_CSR(1'b1)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));
    imm_gen_pipe #(.XLEN(32), .ENABLE_CSR(1'b0)) u_dutnc (.clk(clk), .rst_n(rst_n), .bus(busnc));

    assign bus64.in_valid  = bus.in_valid;
    assign bus64.in_instr  = bus.in_instr;
    assign bus64.out_ready = bus.out_ready;
    assign busnc.in_valid  = bus.in_valid;
    assign busnc.in_instr  = bus.in_instr;
    assign busnc.out_ready = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then check the result it produced.
    task automatic send_check(input string tag, input logic [31:0] instr,
                              input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        step();
        bus.in_valid = 1'b0;
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_imm"}, 64'(bus.out_imm), 64'(imm));
        check({tag, "_fmt"}, 64'(bus.out_fmt), 64'(fmt));
        check({tag, "_ill"}, 64'(bus.out_illegal), 64'(ill));
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_imm", 64'(bus.out_imm), 64'd0);
        check("rst_fmt", 64'(bus.out_fmt), 64'd0);
        check("rst_ill", 64'(bus.out_illegal), 64'd0);
        check("rst_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);

        send_check("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        send_check("beq", 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
        send_check("csrrwi", 32'h300FD073, 32'h0000001F, 3'd6, 1'b0);
        check("nocsr_ill", 64'(busnc.out_illegal), 64'd1);
        check("nocsr_fmt", 64'(busnc.out_fmt), 64'd0);
        check("nocsr_imm", 64'(busnc.out_imm), 64'd0);
        send_check("lui32", 32'h800000B7, 32'h80000000, 3'd4, 1'b0);
        check("lui64_imm", bus64.out_imm, 64'hFFFFFFFF80000000);
        check("lui64_fmt", 64'(bus64.out_fmt), 64'd4);
        send_check("zero", 32'h00000000, 32'h0, 3'd0, 1'b1);
        send_check("sw", 32'h00112623, 32'h0000000C, 3'd2, 1'b0);
        send_check("jal", 32'hFF9FF06F, 32'hFFFFFFF8, 3'd5, 1'b0);
        send_check("add", 32'h002081B3, 32'h0, 3'd0, 1'b0);
        send_check("ecall", 32'h00000073, 32'h0, 3'd1, 1'b0);
        send_check("csrrw", 32'h34011073, 32'h00000340, 3'd1, 1'b0);
        check("csrrw64_imm", bus64.out_imm, 64'h0000000000000340);
        step();
        check("drained", 64'(bus.out_valid), 64'd0);

        // Backpressure: three back-to-back offers with the consumer stalled.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        step();
        check("bp1_ready", 64'(bus.in_ready), 64'd1);
        check("bp1_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
        bus.in_instr = 32'h00112623;
        step();
        check("bp2_ready", 64'(bus.in_ready), 64'd0);
        check("bp2_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
        bus.in_instr = 32'hFF9FF06F;
        step();
        check("bp3_ready", 64'(bus.in_ready), 64'd0);
        check("bp3_stable_imm", 64'(bus.out_imm), 64'hFFFFFFFF);
        check("bp3_stable_fmt", 64'(bus.out_fmt), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp4_imm", 64'(bus.out_imm), 64'h0000000C);
        check("bp4_fmt", 64'(bus.out_fmt), 64'd2);
        check("bp4_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp5_valid", 64'(bus.out_valid), 64'd1);
        check("bp5_imm", 64'(bus.out_imm), 64'hFFFFFFF8);
        check("bp5_fmt", 64'(bus.out_fmt), 64'd5);
        step();
        check("bp6_valid", 64'(bus.out_valid), 64'd0);

        // Mid-operation reset with two entries buffered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        step();
        bus.in_instr = 32'hFE000EE3;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_ready", 64'(bus.in_ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_imm", 64'(bus.out_imm), 64'd0);
        check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
        check("post_rst_ready2", 64'(bus.in_ready), 64'd1);
        send_check("addi_again", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
